// File: rtl/load_store_unit.sv
// load_store_unit
//
// Data-memory access stage sitting behind the instruction decoder. It accepts
// one load or store per request, runs a single req/ack bus transaction for it,
// places store data on the correct byte lanes and sign- or zero-extends the
// returned load data for writeback. The pipeline is held through stall_out
// while a transaction is outstanding. Misaligned or illegal requests are
// rejected without a bus cycle, and a transaction that never sees an ack is
// aborted after TIMEOUT cycles.
//
// Ports:
//   clk_in, rst_n_in        clock, asynchronous active-low reset
//   lsu_valid_in            execute presents a memory operation
//   mem_wr_req_in           1 = store, 0 = load
//   load_size_in            00 byte, 01 half, 10 word, 11 illegal
//   load_unsigned_in        zero-extend loads (byte/half only)
//   addr_in, store_data_in  byte effective address, store source value
//   lsu_ready_out           high when idle; request accepted on valid & ready
//   stall_out               inverse of lsu_ready_out
//   bus_req_out, bus_we_out, bus_addr_out, bus_wstrb_out, bus_wdata_out
//                           registered bus request side
//   bus_ack_in, bus_rdata_in
//                           slave completion and read data (same cycle)
//   load_data_out           extended load result, held until the next load
//   load_valid_out          one-cycle pulse when load_data_out updates
//   misaligned_out          one-cycle pulse for a rejected request
//   bus_err_out             one-cycle pulse for a timed-out transaction

module load_store_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        lsu_valid_in,
  input  logic        mem_wr_req_in,
  input  logic [1:0]  load_size_in,
  input  logic        load_unsigned_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] store_data_in,
  output logic        lsu_ready_out,
  output logic        stall_out,
  output logic        bus_req_out,
  output logic        bus_we_out,
  output logic [31:0] bus_addr_out,
  output logic [3:0]  bus_wstrb_out,
  output logic [31:0] bus_wdata_out,
  input  logic        bus_ack_in,
  input  logic [31:0] bus_rdata_in,
  output logic [31:0] load_data_out,
  output logic        load_valid_out,
  output logic        misaligned_out,
  output logic        bus_err_out
);

  typedef enum logic {
    IDLE = 1'b0,
    BUS  = 1'b1
  } state_t;

  // The counter reaches TIMEOUT on the edge that ends the last allowed wait
  // cycle, so the abort decision is taken while it still holds TIMEOUT-1.
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t      state, next_state;
  logic [7:0]  wait_count;

  logic        cap_we;
  logic [1:0]  cap_size;
  logic        cap_unsigned;
  logic [1:0]  cap_addr_lo;

  logic        accept;
  logic        illegal;
  logic        start;
  logic        complete;
  logic        abort;

  logic [3:0]  wstrb_calc;
  logic [31:0] wdata_calc;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_ext;

  assign lsu_ready_out = (state == IDLE);
  assign stall_out     = ~lsu_ready_out;
  assign accept        = lsu_valid_in & lsu_ready_out;

  // Alignment check on the live request; size 11 is always rejected.
  always_comb begin
    illegal = 1'b0;
    case (load_size_in)
      2'b00:   illegal = 1'b0;
      2'b01:   illegal = addr_in[0];
      2'b10:   illegal = (addr_in[1:0] != 2'b00);
      default: illegal = 1'b1;
    endcase
  end

  // Store lane mapping: data is replicated across lanes so the strobe alone
  // selects which bytes the slave writes.
  always_comb begin
    wstrb_calc = 4'b0000;
    wdata_calc = store_data_in;
    case (load_size_in)
      2'b00: begin
        wstrb_calc = 4'b0001 << addr_in[1:0];
        wdata_calc = {4{store_data_in[7:0]}};
      end
      2'b01: begin
        wstrb_calc = addr_in[1] ? 4'b1100 : 4'b0011;
        wdata_calc = {2{store_data_in[15:0]}};
      end
      default: begin
        wstrb_calc = 4'b1111;
        wdata_calc = store_data_in;
      end
    endcase
  end

  // Load lane extraction uses the address bits and controls captured at
  // acceptance, never the live inputs.
  always_comb begin
    sel_byte = 8'h00;
    sel_half = cap_addr_lo[1] ? bus_rdata_in[31:16] : bus_rdata_in[15:0];
    case (cap_addr_lo)
      2'b00:   sel_byte = bus_rdata_in[7:0];
      2'b01:   sel_byte = bus_rdata_in[15:8];
      2'b10:   sel_byte = bus_rdata_in[23:16];
      default: sel_byte = bus_rdata_in[31:24];
    endcase
    case (cap_size)
      2'b00:   load_ext = {{24{sel_byte[7] & ~cap_unsigned}}, sel_byte};
      2'b01:   load_ext = {{16{sel_half[15] & ~cap_unsigned}}, sel_half};
      default: load_ext = bus_rdata_in;
    endcase
  end

  // State register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; an ack always wins over a timeout in the same cycle.
  always_comb begin
    next_state = state;
    start      = 1'b0;
    complete   = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (accept && !illegal) begin
          start      = 1'b1;
          next_state = BUS;
        end
      end
      BUS: begin
        if (bus_ack_in) begin
          complete   = 1'b1;
          next_state = IDLE;
        end else if (wait_count == LAST_WAIT) begin
          abort      = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Bus outputs, captured request controls, wait counter and result pulses.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      bus_req_out    <= 1'b0;
      bus_we_out     <= 1'b0;
      bus_addr_out   <= 32'h0;
      bus_wstrb_out  <= 4'b0000;
      bus_wdata_out  <= 32'h0;
      load_data_out  <= 32'h0;
      load_valid_out <= 1'b0;
      misaligned_out <= 1'b0;
      bus_err_out    <= 1'b0;
      wait_count     <= 8'h00;
      cap_we         <= 1'b0;
      cap_size       <= 2'b00;
      cap_unsigned   <= 1'b0;
      cap_addr_lo    <= 2'b00;
    end else begin
      load_valid_out <= 1'b0;
      misaligned_out <= 1'b0;
      bus_err_out    <= 1'b0;

      if (accept && illegal) begin
        misaligned_out <= 1'b1;
      end

      if (start) begin
        bus_req_out   <= 1'b1;
        bus_we_out    <= mem_wr_req_in;
        bus_addr_out  <= {addr_in[31:2], 2'b00};
        bus_wstrb_out <= mem_wr_req_in ? wstrb_calc : 4'b0000;
        bus_wdata_out <= wdata_calc;
        wait_count    <= 8'h00;
        cap_we        <= mem_wr_req_in;
        cap_size      <= load_size_in;
        cap_unsigned  <= load_unsigned_in;
        cap_addr_lo   <= addr_in[1:0];
      end

      if (complete) begin
        bus_req_out   <= 1'b0;
        bus_we_out    <= 1'b0;
        bus_wstrb_out <= 4'b0000;
        if (!cap_we) begin
          load_data_out  <= load_ext;
          load_valid_out <= 1'b1;
        end
      end else if (abort) begin
        bus_req_out   <= 1'b0;
        bus_we_out    <= 1'b0;
        bus_wstrb_out <= 4'b0000;
        bus_err_out   <= 1'b1;
      end else if (state == BUS) begin
        wait_count <= wait_count + 8'h01;
      end
    end
  end

endmodule
